// File: rtl/bk_arith_pkg.sv
// Shared definitions for the pipelined Brent-Kung subtractor.
//   WIDTH  : operand width (fixed at 32)
//   HALF   : width of each per-stage prefix adder
//   STAGES : number of pipeline register stages
//   s1_t   : payload carried from stage 1 to stage 2
package bk_arith_pkg;

  localparam int WIDTH  = 32;
  localparam int HALF   = WIDTH / 2;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [HALF-1:0] y_lo;   // resolved low half of the difference
    logic            c16;    // carry into the high half (inverted borrow)
    logic [HALF-1:0] a_hi;
    logic [HALF-1:0] b_hi;
    logic            a_msb;  // operand sign bits, kept for the overflow flag
    logic            b_msb;
  } s1_t;

endpackage

// File: rtl/bk_adder_16.sv
// Combinational Brent-Kung prefix adder with carry-in and carry-out.
//   a, b : addends (W bits, W a power of two)
//   cin  : carry-in
//   sum  : a + b + cin, low W bits
//   cout : carry-out of the top bit
module bk_adder_16
  import bk_arith_pkg::*;
#(
  parameter int W = HALF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LOG  = $clog2(W);
  // stage 0 = bit g/p, stages 1..LOG = up-sweep, LOG+1..LAST = down-sweep
  localparam int LAST = 2 * LOG - 1;

  logic [W-1:0] pb;
  assign pb = a ^ b;

  for (genvar s = 0; s <= LAST; s++) begin : g_stage
    logic [W-1:0] g, p;
    if (s == 0) begin : g_init
      // cin folds into bit 0's generate so every prefix G is a true carry
      assign g = (a & b) | {{(W-1){1'b0}}, pb[0] & cin};
      assign p = pb;
    end else begin : g_lvl
      for (genvar i = 0; i < W; i++) begin : g_bit
        localparam bit UP    = (s <= LOG);
        localparam int D     = UP ? s : 2 * LOG - s;
        localparam int SPAN  = 1 << D;
        localparam int H     = SPAN / 2;
        // up-sweep merges at the top of each 2^D block; down-sweep fills
        // the midpoints of blocks whose lower neighbour is already complete
        localparam bit MERGE = UP ? (((i + 1) % SPAN) == 0)
                                  : ((i >= SPAN) && (((i + 1) % SPAN) == H));
        if (MERGE) begin : g_op
          assign g[i] = g_stage[s-1].g[i] | (g_stage[s-1].p[i] & g_stage[s-1].g[i-H]);
          assign p[i] = g_stage[s-1].p[i] & g_stage[s-1].p[i-H];
        end else begin : g_pass
          assign g[i] = g_stage[s-1].g[i];
          assign p[i] = g_stage[s-1].p[i];
        end
      end
    end
  end

  assign sum  = pb ^ {g_stage[LAST].g[W-2:0], cin};
  assign cout = g_stage[LAST].g[W-1];

  // Final-stage group propagates have no consumer; carries come from g only.
  logic unused_p;
  assign unused_p = ^g_stage[LAST].p;

endmodule

// File: rtl/bk_subtractor_pipe_32.sv
// Two-stage pipelined 32-bit subtractor: Y = A - B - bin (mod 2^32).
// Stage 1 resolves the low half and registers the inter-half carry;
// stage 2 resolves the high half and the flags, and drives the outputs.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake for A, B, bin
//   out_valid / out_ready: output handshake for Y, bout, zero, ovf
//   bout : 1 when unsigned A < B + bin
//   zero : Y == 0
//   ovf  : signed overflow of the subtraction
module bk_subtractor_pipe_32
  import bk_arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  logic [STAGES:1] vld_pipe;  // [1] = stage 1 holds data, [2] = out_valid
  logic            s2_adv, accept;
  s1_t             s1_d, s1_q;

  assign out_valid = vld_pipe[2];
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  assign accept    = in_valid && in_ready;

  // Stage 1: low half of A + ~B + ~bin
  logic [HALF-1:0] lo_sum;
  logic            c16;

  bk_adder_16 #(.W(HALF)) u_add_lo (
    .a    (A[HALF-1:0]),
    .b    (~B[HALF-1:0]),
    .cin  (~bin),
    .sum  (lo_sum),
    .cout (c16)
  );

  always_comb begin
    s1_d       = '0;
    s1_d.y_lo  = lo_sum;
    s1_d.c16   = c16;
    s1_d.a_hi  = A[WIDTH-1:HALF];
    s1_d.b_hi  = B[WIDTH-1:HALF];
    s1_d.a_msb = A[WIDTH-1];
    s1_d.b_msb = B[WIDTH-1];
  end

  // Stage 2: high half, carried in through c16
  logic [HALF-1:0]  hi_sum;
  logic             c_out;
  logic [WIDTH-1:0] y_full;

  bk_adder_16 #(.W(HALF)) u_add_hi (
    .a    (s1_q.a_hi),
    .b    (~s1_q.b_hi),
    .cin  (s1_q.c16),
    .sum  (hi_sum),
    .cout (c_out)
  );

  assign y_full = {hi_sum, s1_q.y_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      Y        <= '0;
      bout     <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        // outputs only change when a new result lands, so a stalled
        // result stays put and an empty slot keeps its last value
        if (vld_pipe[1]) begin
          Y    <= y_full;
          bout <= ~c_out;
          zero <= (y_full == '0);
          ovf  <= (s1_q.a_msb != s1_q.b_msb) && (hi_sum[HALF-1] != s1_q.a_msb);
        end
      end
      // in_ready implies stage 1 is empty or draining this cycle
      if (in_ready) vld_pipe[1] <= in_valid;
      if (accept)   s1_q        <= s1_d;
    end
  end

endmodule
